// File: rtl/sensor_alarm.sv
// Debounced sensor fault alarm: qualifies the error level, latches a fault snapshot and
// holds a sticky alarm until acknowledged. Define SENSOR_ALARM_SYNC_EN to add 2-flop input synchronizers.
module sensor_alarm #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             error,
  input  logic [3:0]       sensors,
  input  logic             ack,
  output logic             alarm,
  output logic [3:0]       fault_code,
  output logic [CNT_W-1:0] fault_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    QUALIFY    = 2'd1,
    ALARM      = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_e;

  localparam logic [7:0] QMAX = 8'(DEBOUNCE - 1);

  logic       error_s;
  logic [3:0] sensors_s;

`ifdef SENSOR_ALARM_SYNC_EN
  logic [4:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {error, sensors};
      sync2_q <= sync1_q;
    end
  end

  assign {error_s, sensors_s} = sync2_q;
`else
  assign error_s   = error;
  assign sensors_s = sensors;
`endif

  state_e           state_q, state_d;
  logic [7:0]       qcnt_q, qcnt_d;
  logic             alarm_q, alarm_d;
  logic             busy_q, busy_d;
  logic [3:0]       fault_code_q, fault_code_d;
  logic [CNT_W-1:0] fault_count_q, fault_count_d;
  logic             enter_alarm;

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      qcnt_q        <= '0;
      alarm_q       <= 1'b0;
      busy_q        <= 1'b0;
      fault_code_q  <= '0;
      fault_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      qcnt_q        <= qcnt_d;
      alarm_q       <= alarm_d;
      busy_q        <= busy_d;
      fault_code_q  <= fault_code_d;
      fault_count_q <= fault_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    qcnt_d  = qcnt_q;
    unique case (state_q)
      IDLE: begin
        if (error_s) begin
          if (DEBOUNCE == 1) begin
            state_d = ALARM;
          end else begin
            state_d = QUALIFY;
            qcnt_d  = 8'd1;
          end
        end
      end
      QUALIFY: begin
        if (!error_s) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q == QMAX) begin
          state_d = ALARM;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + 8'd1;
        end
      end
      ALARM: begin
        if (ack) state_d = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (!error_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the next state so outputs are registered with it.
  always_comb begin
    enter_alarm   = (state_d == ALARM) && (state_q != ALARM);
    alarm_d       = (state_d == ALARM);
    busy_d        = (state_d != IDLE);
    fault_code_d  = fault_code_q;
    fault_count_d = fault_count_q;
    if (enter_alarm) begin
      fault_code_d = sensors_s;
      if (!(&fault_count_q)) fault_count_d = fault_count_q + CNT_W'(1);
    end
  end

  assign alarm       = alarm_q;
  assign busy        = busy_q;
  assign fault_code  = fault_code_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_sensor_alarm.sv
// Directed bench for sensor_alarm: main instance DEBOUNCE=4/CNT_W=2 checked through a
// scoreboard queue, plus a DEBOUNCE=1 instance on the same inputs.
module tb_sensor_alarm;

  typedef struct packed {
    logic       alarm;
    logic       busy;
    logic [3:0] code;
    logic [1:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       error;
  logic [3:0] sensors;
  logic       ack;

  logic       alarm, busy;
  logic [3:0] fault_code;
  logic [1:0] fault_count;

  logic       alarm1, busy1;
  logic [3:0] fault_code1;
  logic [7:0] fault_count1;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  sensor_alarm #(.DEBOUNCE(4), .CNT_W(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .error(error), .sensors(sensors), .ack(ack),
    .alarm(alarm), .fault_code(fault_code), .fault_count(fault_count), .busy(busy)
  );

  sensor_alarm #(.DEBOUNCE(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .error(error), .sensors(sensors), .ack(ack),
    .alarm(alarm1), .fault_code(fault_code1), .fault_count(fault_count1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic e, input logic [3:0] s, input logic a,
                      input logic ea, input logic eb, input logic [3:0] ec, input logic [1:0] en);
    exp_t x;
    error   = e;
    sensors = s;
    ack     = a;
    sb.push_back('{alarm: ea, busy: eb, code: ec, count: en});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".alarm"}, 8'(alarm), 8'(x.alarm));
    chk({tag, ".busy"},  8'(busy),  8'(x.busy));
    chk({tag, ".code"},  8'(fault_code),  8'(x.code));
    chk({tag, ".count"}, 8'(fault_count), 8'(x.count));
  endtask

  initial begin
    n_rst   = 1'b0;
    error   = 1'b1;
    sensors = 4'hF;
    ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.alarm", 8'(alarm), 8'd0);
    chk("rst.busy",  8'(busy),  8'd0);
    chk("rst.code",  8'(fault_code),  8'd0);
    chk("rst.count", 8'(fault_count), 8'd0);
    chk("rst.alarm1", 8'(alarm1), 8'd0);
    error   = 1'b0;
    sensors = 4'h0;
    n_rst   = 1'b1;

`ifndef SENSOR_ALARM_SYNC_EN
    // Qualified fault: alarm after the 4th edge with error high.
    step("q0", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    step("q1", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    step("q2", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    step("q3", 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 4'h6, 2'd1);
    // Ack with error still high, then clear.
    step("ack0", 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 4'h6, 2'd1);
    step("wc_ack", 1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 4'h6, 2'd1);
    step("clr", 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h6, 2'd1);
    step("idle_ack", 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h6, 2'd1);
    // Glitch: 3 high, 1 low, then 4 high; ack during qualify and on the entry edge.
    step("g0", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h6, 2'd1);
    step("g1", 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 4'h6, 2'd1);
    step("g2", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h6, 2'd1);
    step("g_drop", 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h6, 2'd1);
    step("g3", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h6, 2'd1);
    step("g4", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h6, 2'd1);
    step("g5", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h6, 2'd1);
    step("g6", 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 4'h9, 2'd2);
    step("g_hold", 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 4'h9, 2'd2);
    step("g_ack", 1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 4'h9, 2'd2);
    step("g_idle", 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h9, 2'd2);
    // Saturation: three more alarms, count 3,3,3.
    for (int k = 0; k < 3; k++) begin
      logic [3:0] s;
      s = 4'(k + 1);
      step("s_q", 1'b1, s, 1'b0, 1'b0, 1'b1, (k == 0) ? 4'h9 : 4'(k), (k == 0) ? 2'd2 : 2'd3);
      step("s_q", 1'b1, s, 1'b0, 1'b0, 1'b1, (k == 0) ? 4'h9 : 4'(k), (k == 0) ? 2'd2 : 2'd3);
      step("s_q", 1'b1, s, 1'b0, 1'b0, 1'b1, (k == 0) ? 4'h9 : 4'(k), (k == 0) ? 2'd2 : 2'd3);
      step("s_al", 1'b1, s, 1'b0, 1'b1, 1'b1, s, 2'd3);
      step("s_ack", 1'b1, s, 1'b1, 1'b0, 1'b1, s, 2'd3);
      step("s_clr", 1'b0, s, 1'b0, 1'b0, 1'b0, s, 2'd3);
    end
    // Asynchronous reset while in ALARM.
    step("r_q0", 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'h3, 2'd3);
    step("r_q1", 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'h3, 2'd3);
    step("r_q2", 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'h3, 2'd3);
    step("r_al", 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 4'hC, 2'd3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst.alarm", 8'(alarm), 8'd0);
    chk("arst.busy",  8'(busy),  8'd0);
    chk("arst.code",  8'(fault_code),  8'd0);
    chk("arst.count", 8'(fault_count), 8'd0);
    error = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    // DEBOUNCE=1 instance alarms one edge after error rises.
    step("d1", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    chk("d1.alarm", 8'(alarm1), 8'd1);
    chk("d1.busy",  8'(busy1),  8'd1);
    chk("d1.code",  8'(fault_code1),  8'd5);
    chk("d1.count", fault_count1, 8'd1);
`else
    // Sync build: alarm after edge E+5, code = sensors present before edge E+3.
    step("y0", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    step("y1", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    step("y2", 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    step("y3", 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    step("y4", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    step("y5", 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 4'h4, 2'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sensor_alarm.md
# sensor_alarm

Receiving end of the sensor error flag from the sensor-check logic. Qualifies the raw `error` level over a configurable number of consecutive cycles and latches a fault snapshot. Raises a sticky `alarm` that stays up until the supervisor acknowledges it, then re-arms only after the error line has cleared. Sits between the combinational sensor-check logic and the supervisory controller.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive high samples of `error` required to raise `alarm`. Legal range 1..255.
- `CNT_W`, default 8: width of `fault_count`. Minimum 1.

Ports:
- `clk` in 1: system clock, rising-edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `error` in 1: error level from the sensor-check logic. Asynchronous to `clk` when the sync stage is compiled in.
- `sensors` in 4: raw sensor vector, captured as the fault code.
- `ack` in 1: supervisor acknowledge; single-cycle pulse or level.
- `alarm` out 1: qualified fault present, registered.
- `fault_code` out 4: `sensors` value captured at alarm entry, registered.
- `fault_count` out CNT_W: number of alarm entries since reset; saturates at all-ones.
- `busy` out 1: high whenever the FSM state is not IDLE, registered.

## Operation
- `error_s` and `sensors_s` are the sampled inputs: either after the sync stage or direct (see Configuration).
- A debounce counter `qcnt` (8 bits) counts consecutive cycles with `error_s` high.
- FSM states and transitions:
  - IDLE:
    - `error_s`=1 and DEBOUNCE=1: go to ALARM.
    - `error_s`=1 and DEBOUNCE>1: go to QUALIFY with `qcnt`=1.
    - Otherwise stay in IDLE.
  - QUALIFY:
    - `error_s`=0: go to IDLE and clear `qcnt`.
    - `error_s`=1 and `qcnt`=DEBOUNCE-1: go to ALARM.
    - Otherwise increment `qcnt` and stay.
  - ALARM:
    - `ack`=1: go to WAIT_CLEAR.
    - Otherwise hold. `error_s` is ignored in this state.
  - WAIT_CLEAR:
    - `error_s`=0: go to IDLE.
    - Otherwise hold. `ack` is ignored.
- Actions on the edge that enters ALARM:
  - `fault_code` <= `sensors_s`.
  - `fault_count` <= `fault_count`+1, unless it is already all-ones, in which case it holds.
- `fault_code` holds its value until the next ALARM entry. It is not cleared by `ack`.
- `alarm` is 1 exactly while the state is ALARM.
- `busy` is 1 in QUALIFY, ALARM and WAIT_CLEAR.
- `ack` has no effect in IDLE, QUALIFY or WAIT_CLEAR. It is not stored.
- A continuously high `error` produces one alarm per ack-and-clear cycle. It never re-alarms without `error_s` first going low.

## Timing
- Reset (`n_rst`=0, any time, including mid-qualify or mid-alarm):
  - State is IDLE, `qcnt`=0, sync flops=0.
  - `alarm`=0, `busy`=0, `fault_code`=4'h0, `fault_count`=0.
  - Effect is immediate and asynchronous. Operation resumes on the first rising edge after release.
- Alarm latency, with `error` rising before edge E:
  - Sync compiled out: `alarm` is high after edge E+DEBOUNCE-1.
  - Sync compiled in: `alarm` is high after edge E+DEBOUNCE+1.
  - `busy` rises one edge after `error_s` is first sampled high.
- A single-cycle drop of `error_s` during QUALIFY restarts qualification from zero.
- `ack` sampled high in ALARM at edge A: `alarm`=0 after edge A.
  - If `error_s`=0 at that point, the FSM goes IDLE one edge later, after A+1.
- `ack` high on the same edge that enters ALARM is ignored, because the FSM is not yet in ALARM. The supervisor must hold or re-pulse `ack`.
- `fault_code` and `fault_count` update on the same edge that `alarm` rises. They are valid whenever `alarm`=1.

## Configuration
- `SENSOR_ALARM_SYNC_EN` defined:
  - Two-flop synchronizer on `error` and on each `sensors` bit, all reset to 0.
  - Adds 2 cycles of latency to every `error_s` and `sensors_s` dependency.
- `SENSOR_ALARM_SYNC_EN` undefined:
  - `error_s`=`error` and `sensors_s`=`sensors` directly.
  - Inputs must be synchronous to `clk`.

## Test plan
- Reset values: `n_rst`=0 with `error`=1 and `sensors`=4'hF -> `alarm`=0, `busy`=0, `fault_code`=0, `fault_count`=0. Also assert `n_rst` during ALARM -> all outputs return to these values immediately.
- Qualified fault: DEBOUNCE=4, sync out, `sensors`=4'b0110, `error` high from edge 0 -> `alarm`=1 after edge 3, `fault_code`=4'b0110, `fault_count`=1.
- Glitch rejection: DEBOUNCE=4, `error` high for 3 cycles, low for 1, then high for 4 -> no alarm until after the 4th cycle of the second burst. `fault_count` increments exactly once.
- Ack and re-arm: alarm active, `ack` pulsed with `error` still high -> `alarm`=0 next cycle, `busy` stays 1. Drop `error` -> IDLE. Raise `error` for DEBOUNCE cycles -> second alarm, `fault_count`=2. `ack` pulses in IDLE/WAIT_CLEAR -> no effect.
- Saturation and edge cases: CNT_W=2, five alarm/ack/clear cycles -> `fault_count` sequence 1,2,3,3,3. DEBOUNCE=1 -> `alarm` rises one edge after `error_s` rises.
- Sync build: `SENSOR_ALARM_SYNC_EN` defined, DEBOUNCE=4 -> `alarm` rises after edge E+5. `fault_code` equals the `sensors` value present 2 cycles before that edge.
